emu_step_transactor: RTL and testbench

- Parametrised co-emulation transactor that sits between the host byte interface (Din_emu/Dout_emu/Addr_emu) and an HLS-generated DUT.
- Generalises the fixed 2-in/3-out byte wrapper:
  - stimulus and capture byte counts are parameters;
  - the transactor drives a DUT clock-enable in programmed bursts (step mode);
  - DUT output can be captured automatically when its valid strobe fires.
- The host can advance the DUT N cycles per transaction instead of toggling a clock bit per byte write.

---
 rtl/emu_step_transactor.sv | 191 +++++++++++++++++++
 tb/tb_emu_step_transactor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_step_transactor.sv
`default_nettype none
// ============================================================================
// Module      : emu_step_transactor
// Description : Host-byte to HLS-DUT co-emulation transactor. It drives the
//               DUT clock-enable in bursts of N cycles and captures DUT
//               output. Optional macro EMU_CYCLE_COUNT_EN adds a 32-bit
//               dut_ce pulse counter that is readable by the host.
// Revision    : 1.0 - initial release
// ============================================================================
module emu_step_transactor #(
    parameter int STIM_BYTES  = 2,
    parameter int OUT_BYTES   = 3,
    parameter int AW          = 3,
    parameter int AUTO_CAP    = 1,
    parameter int STOP_ON_VLD = 0
) (
    input  logic                    clk_emu,
    input  logic                    rst_emu_n,
    input  logic [7:0]              Din_emu,
    output logic [7:0]              Dout_emu,
    input  logic [AW-1:0]           Addr_emu,
    input  logic                    wr_emu,
    input  logic                    load_emu,
    input  logic                    get_emu,
    input  logic                    step_emu,
    output logic                    busy_emu,
    output logic                    vld_seen,
    output logic                    dut_ce,
    output logic [8*STIM_BYTES-1:0] dut_in,
    input  logic [8*OUT_BYTES-1:0]  dut_out,
    input  logic                    dut_vld
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [8*STIM_BYTES-1:0] stim_q, stim_d;
    logic [8*STIM_BYTES-1:0] dut_in_q, dut_in_d;
    logic [8*OUT_BYTES-1:0]  cap_q, cap_d;
    logic [7:0]              dout_q, dout_d;
    logic                    vld_seen_q, vld_seen_d;
    logic                    ce_prev_q;

    logic        busy;
    logic        cmd_load, cmd_get, cmd_step, cmd_wr;
    logic        auto_fire, stop_fire, ce;
    logic [31:0] addr_w;
    logic [7:0]  rd_byte;

    assign addr_w = 32'(Addr_emu);
    assign busy   = (state_q != ST_IDLE);

    // Commands that are ignored while busy do not mask lower-priority ones.
    assign cmd_load = load_emu && !busy;
    assign cmd_get  = get_emu && !cmd_load;
    assign cmd_step = step_emu && !busy && !load_emu && !get_emu;
    assign cmd_wr   = wr_emu && !busy && !load_emu && !get_emu && !step_emu;

    assign auto_fire = (AUTO_CAP != 0) && busy && dut_vld && ce_prev_q;
    // Early stop suppresses the enable in the capture cycle so the DUT does
    // not advance past the result it just flagged.
    assign stop_fire = (STOP_ON_VLD != 0) && auto_fire && (state_q == ST_RUN);
    assign ce        = (state_q == ST_RUN) && !stop_fire;

`ifdef EMU_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] cyc_snap_q, cyc_snap_d;

    always_comb begin
        cyc_d      = cyc_q + 32'(ce);
        cyc_snap_d = cyc_snap_q;
        if (cmd_get) begin
            cyc_snap_d = cyc_q;
        end
    end

    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) begin
            cyc_q      <= 32'd0;
            cyc_snap_q <= 32'd0;
        end else begin
            cyc_q      <= cyc_d;
            cyc_snap_q <= cyc_snap_d;
        end
    end
`endif

    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (addr_w == 32'(k)) begin
                rd_byte = cap_q[8*k +: 8];
            end
        end
`ifdef EMU_CYCLE_COUNT_EN
        for (int b = 0; b < 4; b++) begin
            if (addr_w == 32'(OUT_BYTES + b)) begin
                rd_byte = cyc_snap_q[8*b +: 8];
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stim_d     = stim_q;
        dut_in_d   = dut_in_q;
        cap_d      = cap_q;
        dout_d     = dout_q;
        vld_seen_d = vld_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_step) begin
                    cnt_d      = (Din_emu == 8'd0) ? 9'd256 : {1'b0, Din_emu};
                    vld_seen_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 9'd1;
                if (stop_fire || (cnt_q == 9'd1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (auto_fire) begin
            cap_d      = dut_out;
            vld_seen_d = 1'b1;
        end
        if (cmd_get) begin
            cap_d = dut_out;
        end
        if (cmd_load) begin
            dut_in_d = stim_q;
        end
        if (cmd_wr) begin
            for (int k = 0; k < STIM_BYTES; k++) begin
                if (addr_w == 32'(k)) begin
                    stim_d[8*k +: 8] = Din_emu;
                end
            end
        end
        if (!load_emu && !get_emu) begin
            dout_d = rd_byte;
        end
    end

    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 9'd0;
            stim_q     <= '0;
            dut_in_q   <= '0;
            cap_q      <= '0;
            dout_q     <= 8'h00;
            vld_seen_q <= 1'b0;
            ce_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stim_q     <= stim_d;
            dut_in_q   <= dut_in_d;
            cap_q      <= cap_d;
            dout_q     <= dout_d;
            vld_seen_q <= vld_seen_d;
            ce_prev_q  <= ce;
        end
    end

    assign Dout_emu = dout_q;
    assign busy_emu = busy;
    assign vld_seen = vld_seen_q;
    assign dut_ce   = ce;
    assign dut_in   = dut_in_q;

endmodule
`default_nettype wire

// File: tb/tb_emu_step_transactor.sv
`default_nettype none
// ============================================================================
// Module      : tb_emu_step_transactor
// Description : Directed bench for emu_step_transactor. Instance a uses
//               STOP_ON_VLD=0 and instance b uses STOP_ON_VLD=1. The expected
//               counter bytes depend on EMU_CYCLE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emu_step_transactor;

    logic        clk_emu = 1'b0;
    logic        rst_emu_n;
    logic [7:0]  Din_emu;
    logic [2:0]  Addr_emu;
    logic        wr_emu, load_emu, get_emu, step_emu;
    logic [7:0]  dout_a, dout_b;
    logic        busy_a, busy_b, vs_a, vs_b, ce_a, ce_b;
    logic [15:0] din_a, din_b;
    logic [23:0] out_a, out_b, out_drv;
    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic        mdl_arm, mdl_clr;
    int          mpc_a = 0, mpc_b = 0;
    int          n_cmp = 0, n_mis = 0;

    always #5 clk_emu = ~clk_emu;

    emu_step_transactor #(.STIM_BYTES(2), .OUT_BYTES(3), .AW(3), .AUTO_CAP(1), .STOP_ON_VLD(0)) u_dut_a (
        .clk_emu(clk_emu), .rst_emu_n(rst_emu_n), .Din_emu(Din_emu), .Dout_emu(dout_a),
        .Addr_emu(Addr_emu), .wr_emu(wr_emu), .load_emu(load_emu), .get_emu(get_emu),
        .step_emu(step_emu), .busy_emu(busy_a), .vld_seen(vs_a), .dut_ce(ce_a),
        .dut_in(din_a), .dut_out(out_a), .dut_vld(vld_a));

    emu_step_transactor #(.STIM_BYTES(2), .OUT_BYTES(3), .AW(3), .AUTO_CAP(1), .STOP_ON_VLD(1)) u_dut_b (
        .clk_emu(clk_emu), .rst_emu_n(rst_emu_n), .Din_emu(Din_emu), .Dout_emu(dout_b),
        .Addr_emu(Addr_emu), .wr_emu(wr_emu), .load_emu(load_emu), .get_emu(get_emu),
        .step_emu(step_emu), .busy_emu(busy_b), .vld_seen(vs_b), .dut_ce(ce_b),
        .dut_in(din_b), .dut_out(out_b), .dut_vld(vld_b));

    // DUT model: raises valid for the one cycle after its 3rd enabled clock.
    always @(posedge clk_emu) begin
        if (mdl_clr) mpc_a <= 0; else if (ce_a) mpc_a <= mpc_a + 1;
        if (mdl_clr) mpc_b <= 0; else if (ce_b) mpc_b <= mpc_b + 1;
        vld_a <= mdl_arm && !mdl_clr && ce_a && (mpc_a == 2);
        vld_b <= mdl_arm && !mdl_clr && ce_b && (mpc_b == 2);
    end
    assign out_a = vld_a ? 24'h12345F : out_drv;
    assign out_b = vld_b ? 24'h12345F : out_drv;

    task automatic tick();
        @(posedge clk_emu);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] da, output logic [7:0] db);
        Addr_emu = a;
        tick();
        da = dout_a;
        db = dout_b;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        Addr_emu = a; Din_emu = d; wr_emu = 1'b1;
        tick();
        wr_emu = 1'b0; Din_emu = 8'h00;
    endtask

    task automatic pulse_load();
        load_emu = 1'b1;
        tick();
        load_emu = 1'b0;
    endtask

    task automatic run(input logic [7:0] n, output int pa, output int pb,
                       output int ba, output int bb, output int span);
        int first, last;
        first = -1; last = -1;
        pa = 0; pb = 0; ba = 0; bb = 0;
        Din_emu = n; step_emu = 1'b1; mdl_clr = 1'b1;
        tick();
        step_emu = 1'b0; mdl_clr = 1'b0; Din_emu = 8'h00;
        for (int c = 0; c < 300 && (busy_a || busy_b); c++) begin
            if (ce_a) begin pa++; if (first < 0) first = c; last = c; end
            if (ce_b) pb++;
            if (busy_a) ba++;
            if (busy_b) bb++;
            tick();
        end
        span = (pa > 0) ? (last - first + 1) : 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] da, db;
        logic [7:0] exp_cnt [4];
        int pa, pb, ba, bb, span;

        rst_emu_n = 1'b0; Din_emu = 8'h00; Addr_emu = 3'd0;
        wr_emu = 1'b0; load_emu = 1'b0; get_emu = 1'b0; step_emu = 1'b0;
        out_drv = 24'h0; mdl_arm = 1'b0; mdl_clr = 1'b0;
        repeat (3) tick();
        rst_emu_n = 1'b1;
        tick();

        check("rst_busy", busy_a, 0);
        check("rst_ce", ce_a, 0);
        check("rst_dut_in", din_a, 0);
        check("rst_vld_seen", vs_a, 0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), da, db);
            check($sformatf("rst_rd_a%0d", a), da, 8'h00);
            check($sformatf("rst_rd_b%0d", a), db, 8'h00);
        end

        // Stimulus writes and load
        wr(3'd0, 8'h01);
        wr(3'd1, 8'hA5);
        check("dut_in_before_load", din_a, 16'h0000);
        pulse_load();
        check("dut_in_load", din_a, 16'hA501);
        wr(3'd5, 8'hFF);
        wr(3'd2, 8'hEE);
        pulse_load();
        check("dut_in_oob_wr", din_a, 16'hA501);

        // load outranks wr in the same cycle
        Addr_emu = 3'd0; Din_emu = 8'h77; wr_emu = 1'b1; load_emu = 1'b1;
        tick();
        wr_emu = 1'b0; load_emu = 1'b0; Din_emu = 8'h00;
        pulse_load();
        check("prio_load_over_wr", din_a, 16'hA501);

        // Manual capture
        out_drv = 24'hC0FFEE; get_emu = 1'b1;
        tick();
        get_emu = 1'b0; out_drv = 24'h0;
        rd(3'd0, da, db); check("get_rd0", da, 8'hEE);
        rd(3'd1, da, db); check("get_rd1", da, 8'hFF);
        rd(3'd2, da, db); check("get_rd2", da, 8'hC0);

        // Step runs without valid
        run(8'd4, pa, pb, ba, bb, span);
        check("run4_pulses", pa, 4);
        check("run4_contig", span, 4);
        check("run4_busy", ba, 5);
        check("run4_pulses_b", pb, 4);
        check("run4_idle_busy", busy_a, 0);
        check("run4_idle_ce", ce_a, 0);
        run(8'd0, pa, pb, ba, bb, span);
        check("run256_pulses", pa, 256);
        check("run256_contig", span, 256);
        check("run256_busy", ba, 257);
        check("run256_vld_seen", vs_a, 0);

        // Auto-capture: a runs all 6 pulses, b stops after the 3rd
        mdl_arm = 1'b1;
        run(8'd6, pa, pb, ba, bb, span);
        mdl_arm = 1'b0;
        check("vld_pulses_a", pa, 6);
        check("vld_busy_a", ba, 7);
        check("vld_pulses_b", pb, 3);
        check("vld_busy_b", bb, 5);
        check("vld_seen_a", vs_a, 1);
        check("vld_seen_b", vs_b, 1);
        rd(3'd0, da, db); check("vld_rd0_a", da, 8'h5F); check("vld_rd0_b", db, 8'h5F);
        rd(3'd1, da, db); check("vld_rd1_a", da, 8'h34); check("vld_rd1_b", db, 8'h34);
        rd(3'd2, da, db); check("vld_rd2_a", da, 8'h12); check("vld_rd2_b", db, 8'h12);

        // Commands during a run: load, step and wr are ignored
        wr(3'd0, 8'h33);
        Din_emu = 8'd10; step_emu = 1'b1; mdl_clr = 1'b1;
        tick();
        step_emu = 1'b0; mdl_clr = 1'b0; Din_emu = 8'h00;
        pa = 0;
        for (int c = 0; c < 40 && busy_a; c++) begin
            if (ce_a) pa++;
            load_emu = (c == 2);
            step_emu = (c == 4);
            wr_emu   = (c == 6);
            Addr_emu = 3'd1;
            Din_emu  = (c == 4) ? 8'd3 : ((c == 6) ? 8'h99 : 8'h00);
            tick();
        end
        load_emu = 1'b0; step_emu = 1'b0; wr_emu = 1'b0; Din_emu = 8'h00;
        check("busy_pulses", pa, 10);
        check("busy_load_ignored", din_a, 16'hA501);
        check("busy_vld_seen_clr", vs_a, 0);
        check("busy_step_ignored", busy_a, 0);
        pulse_load();
        check("busy_wr_ignored", din_a, 16'hA533);

        // Reset in the middle of a 10-cycle run, after pulse 2
        Din_emu = 8'd10; step_emu = 1'b1; mdl_clr = 1'b1;
        tick();
        step_emu = 1'b0; mdl_clr = 1'b0; Din_emu = 8'h00;
        tick();
        tick();
        rst_emu_n = 1'b0;
        #1;
        check("midrst_ce", ce_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_dut_in", din_a, 0);
        tick();
        rst_emu_n = 1'b1;
        pa = 0;
        for (int c = 0; c < 20; c++) begin
            if (ce_a) pa++;
            tick();
        end
        check("midrst_no_pulses", pa, 0);

        // Cycle counter: 4 + 256 pulses after reset, snapshot on get
`ifdef EMU_CYCLE_COUNT_EN
        exp_cnt[0] = 8'h04; exp_cnt[1] = 8'h01; exp_cnt[2] = 8'h00; exp_cnt[3] = 8'h00;
`else
        exp_cnt[0] = 8'h00; exp_cnt[1] = 8'h00; exp_cnt[2] = 8'h00; exp_cnt[3] = 8'h00;
`endif
        run(8'd4, pa, pb, ba, bb, span);
        run(8'd0, pa, pb, ba, bb, span);
        get_emu = 1'b1;
        tick();
        get_emu = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rd(3'(3 + b), da, db);
            check($sformatf("cyc_rd%0d", 3 + b), da, exp_cnt[b]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
